// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled mid-bit sampling and framing-error flag
//
// baud_tick_gen: fractional-accumulator tick generator
//   clk, aresetn   clock and asynchronous active-low reset
//   tick           1-clock pulse, BAUD_RATE*OVERSAMPLING times per second on average
//
// uart_rx: receiver top
//   i_clk, i_aresetn   clock and asynchronous active-low reset
//   i_rx_data          asynchronous serial line, idle high
//   o_rx_data          last correctly framed byte, held until the next good frame
//   o_rx_done          1-clock pulse when o_rx_data is updated
//   o_frame_err        1-clock pulse when the stop bit is sampled low

module baud_tick_gen #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLING = 16
) (
    input  logic clk,
    input  logic aresetn,
    output logic tick
);

    // Accumulator holds values below CLK_FREQ; one extra bit covers acc + inc.
    localparam int ACC_W = $clog2(CLK_FREQ) + 1;
    localparam logic [ACC_W-1:0] INC   = ACC_W'(BAUD_RATE * OVERSAMPLING);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc + INC;

    // Fractional division keeps the long-term tick rate exact even when
    // CLK_FREQ is not a multiple of BAUD_RATE*OVERSAMPLING.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (acc_sum >= LIMIT) begin
            acc  <= acc_sum - LIMIT;
            tick <= 1'b1;
        end else begin
            acc  <= acc_sum;
            tick <= 1'b0;
        end
    end

endmodule

module uart_rx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLING = 16
) (
    input  logic       i_clk,
    input  logic       i_aresetn,
    input  logic       i_rx_data,
    output logic [7:0] o_rx_data,
    output logic       o_rx_done,
    output logic       o_frame_err
);

    localparam int TCW = $clog2(OVERSAMPLING);
    localparam logic [TCW-1:0] HALF_TICK = TCW'(OVERSAMPLING / 2 - 1);
    localparam logic [TCW-1:0] LAST_TICK = TCW'(OVERSAMPLING - 1);
    localparam logic [TCW-1:0] TICK_ONE  = TCW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state;
    logic [TCW-1:0] tick_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shifter;
    logic           rx_meta;
    logic           rx_s;
    logic           baud_tick;

    baud_tick_gen #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .OVERSAMPLING(OVERSAMPLING)
    ) u_baud_tick_gen (
        .clk    (i_clk),
        .aresetn(i_aresetn),
        .tick   (baud_tick)
    );

    // Synchroniser flops reset to the idle (high) line level so reset
    // release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shifter     <= '0;
            o_rx_data   <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (!rx_s) begin
                            state <= START;
                        end
                    end
                    START: begin
                        // Re-check at mid start bit; a high line here was a glitch.
                        if (tick_cnt == HALF_TICK) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                    DATA: begin
                        // Counting a full bit from mid start lands on mid data bit.
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shifter  <= {rx_s, shifter[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                    STOP: begin
                        // Leaving at mid stop bit lets the next start edge be seen at once.
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rx_s) begin
                                o_rx_data <= shifter;
                                o_rx_done <= 1'b1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx

module tb_uart_rx;

    localparam int CLK_FREQ     = 100000000;
    localparam int BAUD_RATE    = 6250000;
    localparam int OVERSAMPLING = 16;
    localparam int BIT_CLKS     = CLK_FREQ / BAUD_RATE;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       aresetn;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_good;
    logic       prev_pulse;
    int         total;
    int         bad;

    uart_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .OVERSAMPLING(OVERSAMPLING)
    ) dut (
        .i_clk      (clk),
        .i_aresetn  (aresetn),
        .i_rx_data  (rx_line),
        .o_rx_data  (rx_data),
        .o_rx_done  (rx_done),
        .o_frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_line = v;
        repeat (n) @(posedge clk);
    endtask

    // Serial transmitter model: 8N1, LSB first. stop_low drives the stop bit
    // low only through its sampling point so the line recovers before the
    // receiver re-checks a possible start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_low);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            hold(b[i], BIT_CLKS);
        end
        if (stop_low) begin
            hold(1'b0, BIT_CLKS * 5 / 8);
            hold(1'b1, BIT_CLKS - BIT_CLKS * 5 / 8);
        end else begin
            hold(1'b1, BIT_CLKS);
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        sb.push_back('{err: 1'b0, data: b});
        last_good = b;
        send_frame(b, 1'b0);
    endtask

    task automatic send_bad(input logic [7:0] b);
        sb.push_back('{err: 1'b1, data: last_good});
        send_frame(b, 1'b1);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (aresetn) begin
            if (rx_done || frame_err) begin
                check("exclusive", {31'd0, rx_done & frame_err}, 0);
                check("pulse_width", {31'd0, prev_pulse}, 0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, rx_done, frame_err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("kind", {31'd0, frame_err}, {31'd0, mon_e.err});
                    check("data", {24'd0, rx_data}, {24'd0, mon_e.data});
                end
            end
            prev_pulse = rx_done | frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        logic [7:0] b;
        total      = 0;
        bad        = 0;
        last_good  = 8'h00;
        prev_pulse = 1'b0;
        rx_line    = 1'b1;
        aresetn    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_data", {24'd0, rx_data}, 0);
        check("reset_done", {31'd0, rx_done}, 0);
        check("reset_err", {31'd0, frame_err}, 0);
        aresetn = 1'b1;
        hold(1'b1, 40);

        send_good(8'hA5);
        hold(1'b1, 20);
        wait_drain("drain_a5", 400);

        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h3C);
        wait_drain("drain_b2b", 400);

        hold(1'b0, BIT_CLKS / 4);
        hold(1'b1, BIT_CLKS * 3);
        check("glitch_quiet", sb.size(), 0);
        send_good(8'h5A);
        hold(1'b1, 20);
        wait_drain("drain_5a", 400);

        send_bad(8'h81);
        hold(1'b1, BIT_CLKS * 3);
        wait_drain("drain_err", 400);
        check("err_hold_data", {24'd0, rx_data}, 32'h5A);

        // Reset asserted in the middle of bit 4 of 0xF0, released mid-frame.
        b = 8'hF0;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            hold(b[i], BIT_CLKS);
        end
        hold(b[4], BIT_CLKS / 2);
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_data", {24'd0, rx_data}, 0);
        check("midrst_done", {31'd0, rx_done}, 0);
        check("midrst_err", {31'd0, frame_err}, 0);
        aresetn = 1'b1;
        last_good = 8'h00;
        hold(b[4], BIT_CLKS / 2);
        for (int i = 5; i < 8; i++) begin
            hold(b[i], BIT_CLKS);
        end
        hold(1'b1, BIT_CLKS * 3);
        check("postrst_data", {24'd0, rx_data}, 0);
        check("postrst_quiet", sb.size(), 0);
        send_good(8'h42);
        hold(1'b1, 20);
        wait_drain("drain_42", 400);

        for (int i = 0; i < 256; i++) begin
            send_good(8'($urandom_range(0, 255)));
            hold(1'b1, $urandom_range(0, 20));
        end
        wait_drain("drain_loop", 2000);
        hold(1'b1, 100);
        check("final_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's UART transmitter (8N1, LSB first, idle-high line).
- Synchronises the asynchronous serial input and detects the start bit using oversampled baud ticks from BaudTickGen.
- Samples each bit at mid-bit, then presents the received byte with a one-cycle done strobe.
- Flags framing errors.
- Sits between the external RX pin and the byte-level consumer.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz, passed to BaudTickGen.
BAUD_RATE, 115200, line bit rate, passed to BaudTickGen.
OVERSAMPLING, 16, baud ticks per bit, passed to BaudTickGen; must be even and >= 4.

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_aresetn  input  1  asynchronous active-low reset.
i_rx_data  input  1  serial line, asynchronous to i_clk, idle high.
o_rx_data  output  8  last correctly framed byte; held until the next good frame.
o_rx_done  output  1  one-cycle pulse: o_rx_data updated this cycle.
o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset: i_clk is the clock; i_aresetn is the asynchronous, active-low reset.
  - Reset values: o_rx_data=0, o_rx_done=0, o_frame_err=0.
  - Internal reset state: FSM=IDLE, tick_cnt=0, bit_cnt=0, synchroniser flops=1.
- Input sync: two-flop synchroniser on i_rx_data (rx_s). Only rx_s is used, adding 2 clocks of latency.
- BaudTickGen instance produces baud_tick, a 1-clock pulse OVERSAMPLING times per bit. All FSM actions below occur only on cycles with baud_tick=1.
- Counters: tick_cnt is $clog2(OVERSAMPLING) bits; bit_cnt is 3 bits. The shift register is 8 bits, filled by shifting right with the new bit entering at [7].
- FSM states and transitions:
  - IDLE: on tick with rx_s=0, go to START with tick_cnt=0.
  - START: on each tick, tick_cnt++.
    - When tick_cnt reaches OVERSAMPLING/2-1 (mid start bit), re-check rx_s.
    - If rx_s=0: go to DATA with tick_cnt=0, bit_cnt=0.
    - If rx_s=1: glitch; return to IDLE silently, with no output pulses.
  - DATA: on each tick, tick_cnt++.
    - When tick_cnt reaches OVERSAMPLING-1: shift in rx_s and set tick_cnt=0.
    - If bit_cnt=7, go to STOP; otherwise bit_cnt++.
  - STOP: on each tick, tick_cnt++.
    - When tick_cnt reaches OVERSAMPLING-1: sample rx_s and go to IDLE.
    - If rx_s=1: o_rx_data <= shifter and o_rx_done=1.
    - If rx_s=0: o_frame_err=1, and o_rx_data is unchanged.
- Output timing: outputs are registered, so a pulse appears in the clock after the sampling tick and lasts exactly 1 clock. o_rx_done and o_frame_err are never both high.
- Nominal latency: the done pulse comes about 9.5 bit periods after the start-bit falling edge, plus the 2 synchroniser clocks.
- Back-to-back frames: the FSM re-enters IDLE at mid-stop bit, so a following start bit is detected with no dead time.
- Line held low (break): produces a frame_err. The FSM then returns to IDLE and immediately re-arms on the low line, giving repeated frame_err pulses every ~10 bit periods until the line goes high. This is accepted behaviour.
- Reset mid-frame: returns to the reset state immediately, and the partial byte is discarded. The first frame after reset release is received only if its start edge occurs after release.
- No flow control: if the consumer misses a done pulse, o_rx_data is overwritten by the next good frame.

Test Plan:
- Clean byte, 100 MHz/115200/16: drive 0xA5 (LSB first) with 8680 ns bits -> one o_rx_done pulse, o_rx_data=0xA5, o_frame_err stays 0.
- Back-to-back 0x00, 0xFF, 0x3C with no idle between frames -> three done pulses in order with matching data and no errors.
- Glitch: pull line low for 2 µs (< half bit), then high -> no done, no frame_err, FSM back in IDLE; a following 0x5A frame is received correctly.
- Framing error: send 0x81 with the stop bit driven low -> o_frame_err pulses once, o_rx_data keeps its previous value (0x5A), no done.
- Reset mid-frame: assert i_aresetn low during bit 4 of 0xF0, release while the line is still mid-frame -> all outputs 0 and no spurious done; a subsequent clean 0x42 frame is received.
- Loopback with the team's UART transmitter at the same parameters: 256 random bytes -> every byte received in order, zero errors.
